gf180mcu_fd_sc_mcu7t5v0__or3_evlatch: RTL

Registered three-input OR event latch that sits directly downstream of the 3-input OR cell: it samples A1..A3, produces the registered OR on Z, detects each rising edge of Z as one event and queues the events in a saturating pending counter. The consumer drains events through a VALID/ACK handshake. Used wherever several request or interrupt lines are merged by an OR3 and the merged edge must not be lost between service cycles.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__or3_evlatch.sv | 123 ++++++++++++
 1 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__or3_evlatch.sv
// Registered OR3 event latch: rising edges of the merged OR are queued in a saturating counter.
// Optional SRC capture register enabled by GF180MCU_FD_SC_OR3_EVLATCH_SRC_EN.
module gf180mcu_fd_sc_mcu7t5v0__or3_evlatch #(
    parameter int unsigned CW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          A1,
    input  logic          A2,
    input  logic          A3,
    input  logic          ACK,
    input  logic          CLR,
    output logic          Z,
    output logic          VALID,
    output logic [CW-1:0] PEND,
    output logic          OVF,
    output logic [2:0]    SRC
);

    localparam logic [CW-1:0] PEND_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] PEND_ZERO = '0;
    localparam logic [CW-1:0] PEND_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          z_d;
    logic          evt_c;
    logic          take_c;
    logic [CW-1:0] pend_nx;
    logic          valid_nx;
    logic          ovf_nx;

    assign evt_c  = Z & ~z_d;
    assign take_c = ACK & VALID;

    // Merged OR register and its one-cycle delay for rising-edge detection
    always_ff @(posedge CLK) begin
        if (RST) begin
            Z   <= 1'b0;
            z_d <= 1'b0;
        end else begin
            Z   <= A1 | A2 | A3;
            z_d <= Z;
        end
    end

    // Occupancy state register, kept in step with the pending count
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_EMPTY;
            PEND  <= PEND_ZERO;
            VALID <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            state <= state_nx;
            PEND  <= pend_nx;
            VALID <= valid_nx;
            OVF   <= ovf_nx;
        end
    end

    // Counter update; a simultaneous event and take cancel, even when full
    always_comb begin
        pend_nx  = PEND;
        ovf_nx   = OVF;
        state_nx = state;
        valid_nx = VALID;

        if (CLR) begin
            pend_nx = PEND_ZERO;
            ovf_nx  = 1'b0;
        end else begin
            unique case ({evt_c, take_c})
                2'b10: begin
                    if (state == ST_FULL) begin
                        ovf_nx = 1'b1;
                    end else begin
                        pend_nx = PEND + PEND_ONE;
                    end
                end
                2'b01:   pend_nx = PEND - PEND_ONE;
                default: pend_nx = PEND;
            endcase
        end

        if (pend_nx == PEND_ZERO) begin
            state_nx = ST_EMPTY;
        end else if (pend_nx == PEND_MAX) begin
            state_nx = ST_FULL;
        end else begin
            state_nx = ST_BUSY;
        end
        valid_nx = (pend_nx != PEND_ZERO);
    end

`ifdef GF180MCU_FD_SC_OR3_EVLATCH_SRC_EN
    logic [2:0] a_q;

    // Capture which inputs formed the most recent event, dropped ones included
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q <= 3'b000;
            SRC <= 3'b000;
        end else begin
            a_q <= {A3, A2, A1};
            if (CLR) begin
                SRC <= 3'b000;
            end else if (evt_c) begin
                SRC <= a_q;
            end
        end
    end
`else
    assign SRC = 3'b000;
`endif

endmodule
